fetch_unit: RTL
===============

# fetch_unit

Instruction fetch sequencer that supplies opcodes to the processor control unit. It owns the program counter and fetches 16-bit instruction words from program memory over a req/ack handshake. It presents each instruction for exactly one issue cycle, resolves jumps and halts itself, and sits between program memory and the control unit / datapath.

## Interface
- PC_W, 10, program counter / instruction memory address width
- INSTR_W, 16, instruction word width; opcode field is [INSTR_W-1:INSTR_W-6], jump target field is [PC_W-1:0]
- reloj  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  fetch enable, sampled in IDLE and ISSUE only
- z  in  1  zero flag from datapath, sampled in ISSUE
- imem_req  out  1  read request to program memory
- imem_addr  out  PC_W  read address, equal to pc while imem_req=1
- imem_ack  in  1  memory ack; imem_data valid in the same cycle
- imem_data  in  INSTR_W  instruction word
- instr  out  INSTR_W  latched instruction word
- opcode  out  6  instr opcode field, drives the control unit opcode input
- instr_valid  out  1  one-cycle issue strobe
- pc  out  PC_W  current program counter
- halted  out  1  HALT executed

## Operation
- States: IDLE, REQ, ISSUE, HALTED.
- IDLE: imem_req=0. run=1 -> REQ.
- REQ: imem_req=1, imem_addr=pc. On imem_ack=1, latch imem_data into instr and go to ISSUE. Otherwise hold REQ. run is ignored, so an outstanding request always completes.
- ISSUE: instr_valid=1 and opcode=instr[15:10]. Next pc is decided this cycle:
  - 111100 J: pc <= target.
  - 111101 JZ: pc <= z ? target : pc+1.
  - 111110 JNZ: pc <= z ? pc+1 : target.
  - 111111 HALT: pc unchanged, go to HALTED.
  - Any other opcode: pc <= pc+1.
  - Non-HALT: run=1 -> REQ, run=0 -> IDLE.
- HALTED: halted=1, imem_req=0, pc frozen. Only reset exits this state.
- pc+1 is modulo 2^PC_W: 1023 wraps to 0. target = instr[PC_W-1:0], zero-extended/truncated to PC_W.
- instr and opcode hold their last value outside ISSUE. Consumers qualify them with instr_valid.

## Timing
- Reset (asynchronous assertion, synchronous-edge release): state=IDLE, pc=0, instr=0, opcode=0, instr_valid=0, imem_req=0, imem_addr=0, halted=0.
- Reset asserted in any state, including mid-request: imem_req drops immediately. A late ack after release is ignored because state is IDLE.
- Single-cycle memory (ack in the first REQ cycle): run high in IDLE at cycle 0 -> REQ at 1 -> ISSUE at 2 -> REQ at 3. Throughput is one instruction per 2 cycles while run=1.
- Each memory wait cycle adds one cycle of latency. instr_valid is never asserted for 2 consecutive cycles.
- z is used only in the ISSUE cycle of JZ/JNZ. The datapath guarantees z reflects the previous flag-writing instruction.
- imem_addr is registered with pc and is stable for the whole request.

## Structure
- Shared package (fetch_pkg):
  - state enum.
  - Opcode constants OP_J=6'b111100, OP_JZ=6'b111101, OP_JNZ=6'b111110, OP_HALT=6'b111111.
  - Field-position localparams.
  - All jump/halt opcodes use the 1111?? group, consistent with the control unit's non-incrementing class.
- One natural sub-module: pc_next, combinational next-PC selection from opcode, z, pc and target. The FSM and registers stay in fetch_unit.

## Test plan
- Reset, then run=1, zero-wait memory returning 16'h0400 at addresses 0..3 -> imem_addr 0,1,2,3 on cycles 1,3,5,7; instr_valid on 2,4,6,8; opcode=6'b000001.
- Address 5 holds J to 0x200 (16'hF200) -> after issue, next imem_addr=0x200.
- JZ 0x010 issued with z=1 -> next addr 0x010. Same instruction with z=0 at pc=0x020 -> next addr 0x021. JNZ mirrors both cases.
- ack delayed 3 cycles -> imem_req and imem_addr held steady 4 cycles, one instr_valid pulse, instr equals data from the ack cycle.
- pc=1023 with a non-jump instruction -> next imem_addr=0. HALT (16'hFC00) -> halted=1, no further imem_req, pc unchanged for 20 cycles.
- reset asserted mid-REQ and run dropped during REQ, as separate runs:
  - Reset mid-REQ: imem_req falls without waiting for the clock, pc=0.
  - run dropped during REQ: request still completes, then ISSUE then IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Jump and halt opcodes all live in the 1111?? group.
package fetch_pkg;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 16;
  localparam int OP_W    = 6;
  localparam int OP_MSB  = INSTR_W - 1;
  localparam int OP_LSB  = INSTR_W - OP_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ISSUE,
    ST_HALTED
  } state_t;

  localparam logic [OP_W-1:0] OP_J    = 6'b111100;
  localparam logic [OP_W-1:0] OP_JZ   = 6'b111101;
  localparam logic [OP_W-1:0] OP_JNZ  = 6'b111110;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection for the issue cycle: sequential step,
// unconditional/conditional jump to the target field, or hold on HALT.
module fetch_unit_pc_next
  import fetch_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic            z,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc_nxt,
  output logic            halt
);

  logic [PC_W-1:0] pc_inc;

  // pc + 1 wraps modulo 2^PC_W by truncation
  assign pc_inc = pc + PC_W'(1);

  always_comb begin
    // NOTE: both outputs get a default before the case so no path leaves them
    // unassigned, which would otherwise infer a latch.
    pc_nxt = pc_inc;
    halt   = 1'b0;
    case (opcode)
      OP_J:    pc_nxt = target;
      OP_JZ:   pc_nxt = z ? target : pc_inc;
      OP_JNZ:  pc_nxt = z ? pc_inc : target;
      OP_HALT: begin
        pc_nxt = pc;
        halt   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches over a req/ack handshake
// and issues each instruction for exactly one cycle.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic               reloj,
  input  logic               reset,
  input  logic               run,
  input  logic               z,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    opcode,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  state_t          state;
  logic [PC_W-1:0] pc_nxt;
  logic            halt_op;

  assign opcode    = instr[OP_MSB:OP_LSB];
  assign imem_addr = pc;

  fetch_unit_pc_next u_pc_next (
    .opcode (opcode),
    .z      (z),
    .pc     (pc),
    .target (instr[PC_W-1:0]),
    .pc_nxt (pc_nxt),
    .halt   (halt_op)
  );

  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the later assignment in a
      // branch overrides this default, giving a one-cycle issue strobe.
      instr_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            state    <= ST_REQ;
            imem_req <= 1'b1;
          end
        end
        ST_REQ: begin
          // run is not looked at here: an outstanding request always completes
          if (imem_ack) begin
            instr       <= imem_data;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          pc <= pc_nxt;
          if (halt_op) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end else if (run) begin
            state    <= ST_REQ;
            imem_req <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HALTED: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
